// File: rtl/tdm_demux_1_8.sv
// rtl/tdm_demux_1_8.sv - 1:8 TDM demultiplexer locking to a slot-0 frame sync
module tdm_demux_1_8 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Data_Valid_In,
    input  logic                  Frame_Sync_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    output logic [DATA_WIDTH-1:0] Channel_0_Data_Out,
    output logic [DATA_WIDTH-1:0] Channel_1_Data_Out,
    output logic [DATA_WIDTH-1:0] Channel_2_Data_Out,
    output logic [DATA_WIDTH-1:0] Channel_3_Data_Out,
    output logic [DATA_WIDTH-1:0] Channel_4_Data_Out,
    output logic [DATA_WIDTH-1:0] Channel_5_Data_Out,
    output logic [DATA_WIDTH-1:0] Channel_6_Data_Out,
    output logic [DATA_WIDTH-1:0] Channel_7_Data_Out,
    output logic [7:0]            Channel_Valid_Out,
    output logic [2:0]            Slot_Select_Out,
    output logic                  Frame_Done_Out,
    output logic                  Locked_Out,
    output logic                  Sync_Error_Out
);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            r_state;
    logic [2:0]            r_slot;
    logic [DATA_WIDTH-1:0] r_ch [8];
    logic [7:0]            r_valid;
    logic                  r_frame_done;
    logic                  r_sync_err;
    logic                  w_accept;

    assign w_accept = Enable_In && Data_Valid_In;

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_state      <= ST_HUNT;
            r_slot       <= 3'd0;
            r_valid      <= 8'd0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_ch[i] <= '0;
            end
        end else begin
            // Strobes live for one cycle; a disabled or gap cycle leaves them low.
            r_valid      <= 8'd0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            if (w_accept) begin
                if (r_state == ST_HUNT) begin
                    if (Frame_Sync_In) begin
                        r_ch[0] <= Data_In;
                        r_valid <= 8'b0000_0001;
                        r_slot  <= 3'd1;
                        r_state <= ST_LOCKED;
                    end
                end else if (Frame_Sync_In) begin
                    // Sync always restarts the frame; off slot 0 it is also an error.
                    r_ch[0]    <= Data_In;
                    r_valid    <= 8'b0000_0001;
                    r_slot     <= 3'd1;
                    r_sync_err <= (r_slot != 3'd0);
                end else if (r_slot == 3'd0) begin
                    r_sync_err <= 1'b1;
                    r_state    <= ST_HUNT;
                end else begin
                    r_ch[r_slot] <= Data_In;
                    r_valid      <= 8'b0000_0001 << r_slot;
                    r_frame_done <= (r_slot == 3'd7);
                    r_slot       <= r_slot + 3'd1;
                end
            end
        end
    end

    assign Channel_0_Data_Out = r_ch[0];
    assign Channel_1_Data_Out = r_ch[1];
    assign Channel_2_Data_Out = r_ch[2];
    assign Channel_3_Data_Out = r_ch[3];
    assign Channel_4_Data_Out = r_ch[4];
    assign Channel_5_Data_Out = r_ch[5];
    assign Channel_6_Data_Out = r_ch[6];
    assign Channel_7_Data_Out = r_ch[7];
    assign Channel_Valid_Out  = r_valid;
    assign Slot_Select_Out    = r_slot;
    assign Frame_Done_Out     = r_frame_done;
    assign Locked_Out         = (r_state == ST_LOCKED);
    assign Sync_Error_Out     = r_sync_err;

endmodule
